// File: rtl/mmc_dram_cmd_sequencer.sv
// DRAM command sequencer: turns final-queue entries into ACT/PRE/RD/WR commands with per-bank open-row tracking.
// Optional auto-precharge on same-bank page conflicts: define MMC_DRAM_SEQ_AUTOPRE_EN.
module mmc_dram_cmd_sequencer #(
  parameter int BANK_WIDTH = 2,
  parameter int PAGE_WIDTH = 12,
  parameter int LINE_WIDTH = 5,
  parameter int TRCD       = 4,
  parameter int TRP        = 3
) (
  input  logic                                     clk,
  input  logic                                     reset_poweron,
  input  logic                                     clear,
  input  logic                                     pipe_valid,
  input  logic [BANK_WIDTH+PAGE_WIDTH+LINE_WIDTH:0] pipe_data,
  input  logic                                     pipe_peek_valid,
  input  logic [BANK_WIDTH+PAGE_WIDTH+LINE_WIDTH:0] pipe_peek_data,
  input  logic                                     pipe_peek_twoIn_valid,
  input  logic [BANK_WIDTH+PAGE_WIDTH+LINE_WIDTH:0] pipe_peek_twoIn_data,
  output logic                                     pipe_read,
  output logic                                     cmd_valid,
  input  logic                                     cmd_ready,
  output logic [1:0]                               cmd_type,
  output logic [BANK_WIDTH-1:0]                    cmd_bank,
  output logic [PAGE_WIDTH-1:0]                    cmd_page,
  output logic [LINE_WIDTH-1:0]                    cmd_line,
  output logic                                     cmd_ap,
  output logic [1:0]                               lookahead_match,
  output logic                                     busy
);
  localparam int E     = 1 + BANK_WIDTH + PAGE_WIDTH + LINE_WIDTH;
  localparam int NB    = 1 << BANK_WIDTH;
  localparam int PO    = LINE_WIDTH;
  localparam int BO    = LINE_WIDTH + PAGE_WIDTH;
  localparam int TMAX  = (TRCD > TRP) ? TRCD : TRP;
  localparam int CNT_W = $clog2(TMAX);

  localparam logic [1:0] CT_ACT = 2'b00;
  localparam logic [1:0] CT_PRE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_ACCESS
  } state_t;

  state_t                            state_q;
  logic                              cmd_valid_q;
  logic [1:0]                        cmd_type_q;
  logic [BANK_WIDTH-1:0]             cmd_bank_q;
  logic [PAGE_WIDTH-1:0]             cmd_page_q;
  logic [LINE_WIDTH-1:0]             cmd_line_q;
  logic                              cmd_ap_q;
  logic [NB-1:0]                     open_q;
  logic [NB-1:0][PAGE_WIDTH-1:0]     open_page_q;
  logic [CNT_W-1:0]                  cnt_q;

  logic                  h_op, p_op;
  logic [BANK_WIDTH-1:0] h_bank, p_bank, t_bank;
  logic [PAGE_WIDTH-1:0] h_page, p_page, t_page;
  logic [LINE_WIDTH-1:0] h_line, p_line;
  logic                  h_hit, peek_same_head, two_same_head, peek_same_cmd;
  logic                  head_ap, peek_ap, hs;
  logic                  unused_twoin;

  assign h_op   = pipe_data[E-1];
  assign h_bank = pipe_data[BO +: BANK_WIDTH];
  assign h_page = pipe_data[PO +: PAGE_WIDTH];
  assign h_line = pipe_data[LINE_WIDTH-1:0];
  assign p_op   = pipe_peek_data[E-1];
  assign p_bank = pipe_peek_data[BO +: BANK_WIDTH];
  assign p_page = pipe_peek_data[PO +: PAGE_WIDTH];
  assign p_line = pipe_peek_data[LINE_WIDTH-1:0];
  assign t_bank = pipe_peek_twoIn_data[BO +: BANK_WIDTH];
  assign t_page = pipe_peek_twoIn_data[PO +: PAGE_WIDTH];
  assign unused_twoin = ^{pipe_peek_twoIn_data[E-1], pipe_peek_twoIn_data[LINE_WIDTH-1:0]};

  assign h_hit          = open_q[h_bank] && (open_page_q[h_bank] == h_page);
  assign peek_same_head = pipe_peek_valid && (p_bank == h_bank) && (p_page == h_page);
  assign two_same_head  = pipe_peek_twoIn_valid && (t_bank == h_bank) && (t_page == h_page);
  assign peek_same_cmd  = pipe_peek_valid && (p_bank == cmd_bank_q) && (p_page == cmd_page_q);

`ifdef MMC_DRAM_SEQ_AUTOPRE_EN
  // head_ap applies to the current head, peek_ap to the peek once it becomes the head
  assign head_ap = pipe_peek_valid && (p_bank == h_bank) && (p_page != h_page);
  assign peek_ap = pipe_peek_twoIn_valid && (t_bank == p_bank) && (t_page != p_page);
`else
  assign head_ap = 1'b0;
  assign peek_ap = 1'b0;
`endif

  assign lookahead_match = !(pipe_valid && peek_same_head) ? 2'd0 :
                           two_same_head ? 2'd2 : 2'd1;

  assign hs        = cmd_valid_q & cmd_ready;
  assign pipe_read = hs & (state_q == S_ACCESS) & ~reset_poweron;

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_page  = cmd_page_q;
  assign cmd_line  = cmd_line_q;
  assign cmd_ap    = cmd_ap_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_bank_q  <= '0;
      cmd_page_q  <= '0;
      cmd_line_q  <= '0;
      cmd_ap_q    <= 1'b0;
      open_q      <= '0;
      open_page_q <= '0;
      cnt_q       <= '0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_ap_q    <= 1'b0;
      open_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pipe_valid) begin
            cmd_valid_q <= 1'b1;
            cmd_bank_q  <= h_bank;
            if (h_hit) begin
              state_q    <= S_ACCESS;
              cmd_type_q <= {1'b1, h_op};
              cmd_page_q <= h_page;
              cmd_line_q <= h_line;
              cmd_ap_q   <= head_ap;
            end else if (open_q[h_bank]) begin
              state_q    <= S_PRE;
              cmd_type_q <= CT_PRE;
              cmd_page_q <= '0;
              cmd_line_q <= '0;
              cmd_ap_q   <= 1'b0;
            end else begin
              state_q    <= S_ACT;
              cmd_type_q <= CT_ACT;
              cmd_page_q <= h_page;
              cmd_line_q <= '0;
              cmd_ap_q   <= 1'b0;
            end
          end
        end
        S_PRE: begin
          if (hs) begin
            open_q[cmd_bank_q] <= 1'b0;
            cmd_valid_q        <= 1'b0;
            cnt_q              <= CNT_W'(TRP - 2);
            state_q            <= S_PRE_WAIT;
          end
        end
        S_PRE_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_ACT;
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= CT_ACT;
            cmd_bank_q  <= h_bank;
            cmd_page_q  <= h_page;
            cmd_line_q  <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ACT: begin
          if (hs) begin
            open_q[cmd_bank_q]      <= 1'b1;
            open_page_q[cmd_bank_q] <= cmd_page_q;
            cmd_valid_q             <= 1'b0;
            cnt_q                   <= CNT_W'(TRCD - 2);
            state_q                 <= S_ACT_WAIT;
          end
        end
        S_ACT_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_ACCESS;
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= {1'b1, h_op};
            cmd_bank_q  <= h_bank;
            cmd_page_q  <= h_page;
            cmd_line_q  <= h_line;
            cmd_ap_q    <= head_ap;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ACCESS: begin
          if (hs) begin
            if (cmd_ap_q) open_q[cmd_bank_q] <= 1'b0;
            // the peek becomes the head next cycle, so it can issue straight away
            if (peek_same_cmd && !cmd_ap_q) begin
              cmd_type_q <= {1'b1, p_op};
              cmd_line_q <= p_line;
              cmd_ap_q   <= peek_ap;
            end else begin
              state_q     <= S_IDLE;
              cmd_valid_q <= 1'b0;
              cmd_ap_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_dram_cmd_sequencer.sv
// Directed bench for mmc_dram_cmd_sequencer with a small request-queue model feeding head/peek/twoIn.
module tb_mmc_dram_cmd_sequencer;
  localparam int BW = 2;
  localparam int PW = 12;
  localparam int LW = 5;
  localparam int E  = 1 + BW + PW + LW;

  logic          clk = 1'b0;
  logic          reset_poweron, clear;
  logic          pipe_valid, pipe_peek_valid, pipe_peek_twoIn_valid;
  logic [E-1:0]  pipe_data, pipe_peek_data, pipe_peek_twoIn_data;
  logic          pipe_read, cmd_valid, cmd_ready, cmd_ap, busy;
  logic [1:0]    cmd_type, lookahead_match;
  logic [BW-1:0] cmd_bank;
  logic [PW-1:0] cmd_page;
  logic [LW-1:0] cmd_line;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int p0;
  int n;
  logic [E-1:0] q[$];

  always #5 clk = ~clk;

  mmc_dram_cmd_sequencer #(
    .BANK_WIDTH(BW), .PAGE_WIDTH(PW), .LINE_WIDTH(LW), .TRCD(4), .TRP(3)
  ) dut (
    .clk(clk), .reset_poweron(reset_poweron), .clear(clear),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .pipe_peek_valid(pipe_peek_valid), .pipe_peek_data(pipe_peek_data),
    .pipe_peek_twoIn_valid(pipe_peek_twoIn_valid), .pipe_peek_twoIn_data(pipe_peek_twoIn_data),
    .pipe_read(pipe_read), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_page(cmd_page), .cmd_line(cmd_line),
    .cmd_ap(cmd_ap), .lookahead_match(lookahead_match), .busy(busy)
  );

  function automatic logic [E-1:0] mk(input logic op, input int bank, input int page, input int line);
    return {op, BW'(bank), PW'(page), LW'(line)};
  endfunction

  task automatic drive_q();
    pipe_valid            = (q.size() > 0);
    pipe_data             = (q.size() > 0) ? q[0] : '0;
    pipe_peek_valid       = (q.size() > 1);
    pipe_peek_data        = (q.size() > 1) ? q[1] : '0;
    pipe_peek_twoIn_valid = (q.size() > 2);
    pipe_peek_twoIn_data  = (q.size() > 2) ? q[2] : '0;
  endtask

  task automatic push(input logic [E-1:0] e);
    q.push_back(e);
    drive_q();
    #1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick();
    logic pr;
    #1;
    pr = pipe_read;
    @(posedge clk);
    #1;
    if (pr) begin
      void'(q.pop_front());
      pops++;
    end
    drive_q();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_act(input string tag, input int b, input int p);
    chk(tag, {15'd0, cmd_valid, cmd_type, cmd_bank, cmd_page},
             {15'd0, 1'b1, 2'b00, BW'(b), PW'(p)});
  endtask

  task automatic exp_pre(input string tag, input int b);
    chk(tag, {27'd0, cmd_valid, cmd_type, cmd_bank}, {27'd0, 1'b1, 2'b01, BW'(b)});
  endtask

  task automatic exp_rw(input string tag, input int t, input int b, input int p, input int l);
    chk(tag, {10'd0, cmd_valid, cmd_type, cmd_bank, cmd_page, cmd_line},
             {10'd0, 1'b1, 2'(t), BW'(b), PW'(p), LW'(l)});
  endtask

  initial begin
    reset_poweron = 1'b1;
    clear = 1'b0;
    cmd_ready = 1'b1;
    drive_q();
    @(negedge clk);
    tick();
    tick();
    chk("rst_outputs", {21'd0, cmd_valid, pipe_read, cmd_ap, busy, cmd_type, cmd_bank, cmd_page[2:0]}, 32'd0);
    chk("rst_page_line", {15'd0, cmd_page, cmd_line}, 32'd0);
    reset_poweron = 1'b0;
    tick();

    // Hit burst on closed bank 0
    push(mk(0, 0, 'h12, 0));
    push(mk(0, 0, 'h12, 1));
    push(mk(0, 0, 'h12, 2));
    chk("hit_lookahead", 32'(lookahead_match), 32'd2);
    chk("hit_idle_busy", 32'(busy), 32'd0);
    tick();
    exp_act("hit_act", 0, 'h12);
    tick(); tick(); tick();
    chk("hit_trcd_gap", 32'(cmd_valid), 32'd0);
    tick();
    exp_rw("hit_rd0", 2, 0, 'h12, 0);
    chk("hit_pop0", 32'(pipe_read), 32'd1);
    tick();
    exp_rw("hit_rd1", 2, 0, 'h12, 1);
    tick();
    exp_rw("hit_rd2", 2, 0, 'h12, 2);
    tick();
    chk("hit_done", {30'd0, cmd_valid, busy}, 32'd0);
    chk("hit_pops", 32'(pops), 32'd3);

    // Row miss: open bank 1 page 5, then write page 6
    push(mk(1, 1, 5, 3));
    chk("miss_lookahead_single", 32'(lookahead_match), 32'd0);
    tick();
    exp_act("miss_open_act", 1, 5);
    tick(); tick(); tick(); tick();
    exp_rw("miss_open_wr", 3, 1, 5, 3);
    tick();
    chk("miss_open_idle", 32'(busy), 32'd0);
    push(mk(1, 1, 6, 4));
    tick();
    exp_pre("miss_pre", 1);
    tick(); tick();
    chk("miss_trp_gap", 32'(cmd_valid), 32'd0);
    tick();
    exp_act("miss_act", 1, 6);
    tick(); tick(); tick();
    chk("miss_trcd_gap", 32'(cmd_valid), 32'd0);
    tick();
    exp_rw("miss_wr", 3, 1, 6, 4);
    tick();

    // Same-bank page conflict in the queue: bank 2 page 7 then page 9
    push(mk(0, 2, 7, 1));
    push(mk(0, 2, 9, 2));
    chk("ap_lookahead", 32'(lookahead_match), 32'd0);
    tick();
    exp_act("ap_act7", 2, 7);
    tick(); tick(); tick(); tick();
    exp_rw("ap_rd7", 2, 2, 7, 1);
`ifdef MMC_DRAM_SEQ_AUTOPRE_EN
    chk("ap_flag", 32'(cmd_ap), 32'd1);
`else
    chk("ap_flag", 32'(cmd_ap), 32'd0);
`endif
    tick();
    chk("ap_idle", 32'(busy), 32'd0);
    tick();
`ifdef MMC_DRAM_SEQ_AUTOPRE_EN
    exp_act("ap_second_act", 2, 9);
`else
    exp_pre("ap_second_pre", 2);
`endif
    n = 0;
    while (!(cmd_valid && cmd_type == 2'b10) && n < 20) begin
      tick();
      n++;
    end
`ifdef MMC_DRAM_SEQ_AUTOPRE_EN
    chk("ap_rd9_delay", 32'(n), 32'd4);
`else
    chk("ap_rd9_delay", 32'(n), 32'd7);
`endif
    exp_rw("ap_rd9", 2, 2, 9, 2);
    chk("ap_rd9_flag", 32'(cmd_ap), 32'd0);
    tick();

    // Backpressure on a page hit (bank 2 page 9 is open)
    cmd_ready = 1'b0;
    push(mk(0, 2, 9, 5));
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_rw("bp_hold", 2, 2, 9, 5);
      chk("bp_no_pop", 32'(pipe_read), 32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    #1;
    chk("bp_pop", 32'(pipe_read), 32'd1);
    p0 = pops;
    tick();
    chk("bp_pop_count", 32'(pops - p0), 32'd1);
    chk("bp_done", 32'(cmd_valid), 32'd0);

    // Clear during ACT_WAIT
    push(mk(1, 3, 'h20, 7));
    tick();
    exp_act("clr_act", 3, 'h20);
    tick();
    chk("clr_actwait_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    p0 = pops;
    tick();
    clear = 1'b0;
    chk("clr_idle", {30'd0, busy, cmd_valid}, 32'd0);
    chk("clr_no_pop", 32'(pops - p0), 32'd0);
    tick();
    exp_act("clr_reissue_act", 3, 'h20);
    tick(); tick(); tick(); tick();
    exp_rw("clr_wr", 3, 3, 'h20, 7);
    tick();

    // Reset while a hit handshake is pending
    push(mk(0, 3, 'h20, 1));
    tick();
    exp_rw("rst_hit_rd", 2, 3, 'h20, 1);
    chk("rst_hit_pipe_read", 32'(pipe_read), 32'd1);
    reset_poweron = 1'b1;
    #1;
    chk("rst_blocks_pop", 32'(pipe_read), 32'd0);
    p0 = pops;
    tick();
    chk("rst_mid_outputs", {21'd0, cmd_valid, pipe_read, cmd_ap, busy, cmd_type, cmd_bank, cmd_line[2:0]}, 32'd0);
    chk("rst_mid_page", 32'(cmd_page), 32'd0);
    chk("rst_mid_no_pop", 32'(pops - p0), 32'd0);
    reset_poweron = 1'b0;
    tick();
    exp_act("rst_reopen_act", 3, 'h20);
    tick(); tick(); tick(); tick();
    exp_rw("rst_final_rd", 2, 3, 'h20, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmc_dram_cmd_sequencer.md
# mmc_dram_cmd_sequencer

Consumes memory requests from the output of the main-memory-control final queue: pops the head entry with the queue's `pipe_read` handshake and uses the queue's one- and two-deep peek outputs to plan page handling. Turns each request into DRAM ACTIVATE, PRECHARGE and READ/WRITE commands, tracking open rows per bank and enforcing tRCD and tRP spacing. Sits between the final queue and the DRAM command port of the manager's memory controller.

## Interface
- `BANK_WIDTH`, 2, bank address bits; number of banks is 2^BANK_WIDTH.
- `PAGE_WIDTH`, 12, row (page) address bits.
- `LINE_WIDTH`, 5, column/line address bits.
- `TRCD`, 4, cycles from the ACTIVATE handshake to the earliest READ/WRITE `cmd_valid`; must be ≥2.
- `TRP`, 3, cycles from the PRECHARGE handshake to the earliest ACTIVATE `cmd_valid`; must be ≥2.
- Entry width E = 1+BANK_WIDTH+PAGE_WIDTH+LINE_WIDTH. Entry layout, MSB to LSB: {op (1=write), bank, page, line}.

Ports:
- `clk`  in  1  sole clock.
- `reset_poweron`  in  1  synchronous active-high reset.
- `clear`  in  1  synchronous flush of sequencer state.
- `pipe_valid`  in  1  queue head valid.
- `pipe_data`  in  E  queue head entry.
- `pipe_peek_valid` / `pipe_peek_data`  in  1 / E  second entry.
- `pipe_peek_twoIn_valid` / `pipe_peek_twoIn_data`  in  1 / E  third entry.
- `pipe_read`  out  1  pops the head.
- `cmd_valid`  out  1  command offered.
- `cmd_ready`  in  1  DRAM port accepts.
- `cmd_type`  out  2  00 ACT, 01 PRE, 10 RD, 11 WR.
- `cmd_bank` / `cmd_page` / `cmd_line`  out  BANK_WIDTH / PAGE_WIDTH / LINE_WIDTH  command address.
- `cmd_ap`  out  1  auto-precharge with RD/WR.
- `lookahead_match`  out  2  count (0–2) of valid peek entries sharing the head's bank and page.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Per-bank registers: `open[b]` and `open_page[b]`.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, ACCESS.
- IDLE, with `pipe_valid` and head bank h:
  - `open[h]` set and page equal: go to ACCESS.
  - `open[h]` set and page differs: go to PRE.
  - `open[h]` clear: go to ACT.
- PRE: offer PRE for bank h. On handshake, clear `open[h]` and go to PRE_WAIT.
- PRE_WAIT: count TRP, then go to ACT.
- ACT: offer ACT with head bank and page. On handshake, set `open[h]`, load `open_page[h]`, and go to ACT_WAIT.
- ACT_WAIT: count TRCD, then go to ACCESS.
- ACCESS: offer RD or WR, selected by op.
  - `pipe_read` = `cmd_valid & cmd_ready` in ACCESS only; this is combinational, same cycle as the handshake.
  - After the handshake:
    - If `cmd_ap`, clear `open[h]`.
    - If `pipe_peek_valid` and the peek matches the just-issued bank and page with `cmd_ap`=0, stay in ACCESS (back-to-back hits).
    - Otherwise return to IDLE.
- Command fields are held stable while `cmd_valid`=1 and `cmd_ready`=0.
- `lookahead_match` is combinational. It is 0 when `pipe_valid`=0. The twoIn entry counts only if the peek also matches.
- `clear`: next state IDLE, all `open[b]` cleared, wait counters zeroed. An un-handshaken command is abandoned and no `pipe_read` is issued. The DRAM side is assumed precharged by the controller on clear.
- Simultaneous `clear` and handshake: the handshake completes (`pipe_read` may assert that cycle), and the clear then takes effect.

## Timing
- Reset values:
  - state IDLE.
  - `cmd_valid`, `pipe_read`, `cmd_ap`, `busy`: 0.
  - `cmd_type`, `cmd_bank`, `cmd_page`, `cmd_line`: 0.
  - all `open` flags: 0.
- Reset mid-operation overrides everything, including a pending handshake.
- Page hit from IDLE: `cmd_valid` one cycle after `pipe_valid` is seen.
- Consecutive hits: one RD/WR per cycle while `cmd_ready`=1.
- Closed bank:
  - ACT `cmd_valid` in cycle N+1 after `pipe_valid` is seen in N.
  - ACT handshake in cycle A: RD/WR `cmd_valid` no earlier than A+TRCD.
- PRE handshake in cycle P: ACT `cmd_valid` no earlier than P+TRP.
- Row miss total with zero-stall `cmd_ready`: 1 + TRP + TRCD cycles to the first data command.

## Configuration
- `MMC_DRAM_SEQ_AUTOPRE_EN` defined:
  - `cmd_ap`=1 on RD/WR when `pipe_peek_valid`=1 and the peek targets the same bank with a different page.
  - The bank is then closed, so that bank's next request takes the ACT path with no PRE.
- Undefined: `cmd_ap` is tied 0 and every page conflict uses an explicit PRE.

## Test plan
- Hit burst: closed bank 0, three RD entries bank 0 page 0x12 lines 0,1,2, `cmd_ready`=1 -> ACT(0,0x12), then RD lines 0,1,2 on consecutive cycles starting TRCD=4 after the ACT handshake; 3 `pipe_read` pulses; `lookahead_match` reads 2 at the first head.
- Row miss: bank 1 open page 0x5, head WR bank 1 page 0x6 -> PRE(1), ACT(1,0x6) ≥3 cycles later, WR ≥4 cycles after that.
- Auto-precharge (macro on): entries bank 2 page 7, then bank 2 page 9 -> first RD has `cmd_ap`=1; second request issues ACT with no PRE. With the macro off: `cmd_ap`=0 and an explicit PRE.
- Backpressure: `cmd_ready`=0 for 5 cycles during RD -> fields stable, `pipe_read`=0 throughout, exactly one pop once ready.
- Clear during ACT_WAIT -> IDLE next cycle, no pop, head re-issued starting with ACT.
- Reset asserted in ACCESS with `cmd_ready`=1 -> no `pipe_read`; all outputs 0 the next cycle.
